demux6output16bit_reg: RTL and testbench



---
 rtl/demux6output16bit_reg_pkg.sv | 26 ++
 rtl/demux6output16bit_reg_if.sv | 31 +++
 rtl/demux6output16bit_reg_reg16_en.sv | 28 ++
 rtl/demux6output16bit_reg.sv | 92 +++++++++
 tb/tb_demux6output16bit_reg.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/demux6output16bit_reg_pkg.sv
// Shared constants for the registered 1-to-6 write distributor.
// The select codes match the A..F input order of the 6-input 16-bit select mux.
package demux6_pkg;

  localparam int WIDTH  = 16;
  localparam int NOUT   = 6;
  localparam int SEL_W  = 3;
  localparam int WCNT_W = 8;

  localparam logic [WCNT_W-1:0] WCNT_MAX = 8'd255;

  typedef enum logic [SEL_W-1:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4,
    SEL_F = 3'd5
  } sel_e;

  // Codes 6 and 7 have no destination register.
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return sel <= SEL_F;
  endfunction

endpackage

// File: rtl/demux6output16bit_reg_if.sv
// Write port and register-file view of the distributor.
// The master drives the write request; the slave presents the holding registers and status.
interface demux6output16bit_reg_if;
  import demux6_pkg::*;

  logic [WIDTH-1:0]  d;
  logic [SEL_W-1:0]  s;
  logic              we;
  logic              clr;

  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  c;
  logic [WIDTH-1:0]  d_out;
  logic [WIDTH-1:0]  e;
  logic [WIDTH-1:0]  f;
  logic [NOUT-1:0]   v;
  logic              err;
  logic [WCNT_W-1:0] wcnt;

  modport master (
    output d, s, we, clr,
    input  a, b, c, d_out, e, f, v, err, wcnt
  );

  modport slave (
    input  d, s, we, clr,
    output a, b, c, d_out, e, f, v, err, wcnt
  );

endinterface

// File: rtl/demux6output16bit_reg_reg16_en.sv
// One holding register: load on enable, synchronous clear has priority over load.
module reg16_en
  import demux6_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/demux6output16bit_reg.sv
// Registered 1-to-6 distributor: request stage, then commit into one of six holding
// registers, with per-register valid flags, sticky illegal-select flag and write counter.
module demux6output16bit_reg
  import demux6_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  demux6output16bit_reg_if.slave  bus
);

  logic              r_p_we;
  logic [WIDTH-1:0]  r_p_d;
  logic [SEL_W-1:0]  r_p_s;

  logic [NOUT-1:0]   r_v;
  logic              r_err;
  logic [WCNT_W-1:0] r_wcnt;

  logic [NOUT-1:0]   w_en;
  logic              w_legal;
  logic              w_illegal;
  logic [WIDTH-1:0]  w_q [NOUT];

  // NOTE: the pending stage is reset as well, so a request in flight at reset can never commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p_we <= 1'b0;
      r_p_d  <= '0;
      r_p_s  <= '0;
    end else if (bus.clr) begin
      r_p_we <= 1'b0;
      r_p_d  <= '0;
      r_p_s  <= '0;
    end else begin
      r_p_we <= bus.we;
      r_p_d  <= bus.d;
      r_p_s  <= bus.s;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_en      = '0;
    w_legal   = r_p_we && sel_legal(r_p_s);
    w_illegal = r_p_we && !sel_legal(r_p_s);
    for (int i = 0; i < NOUT; i++) begin
      w_en[i] = w_legal && (r_p_s == SEL_W'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v    <= '0;
      r_err  <= 1'b0;
      r_wcnt <= '0;
    end else if (bus.clr) begin
      r_v    <= '0;
      r_err  <= 1'b0;
      r_wcnt <= '0;
    end else begin
      r_v <= r_v | w_en;
      if (w_illegal) begin
        r_err <= 1'b1;
      end
      if (w_legal && (r_wcnt != WCNT_MAX)) begin
        r_wcnt <= r_wcnt + WCNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NOUT; g++) begin : g_regs
    reg16_en u_reg (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (bus.clr),
      .i_en    (w_en[g]),
      .i_d     (r_p_d),
      .o_q     (w_q[g])
    );
  end

  assign bus.a     = w_q[0];
  assign bus.b     = w_q[1];
  assign bus.c     = w_q[2];
  assign bus.d_out = w_q[3];
  assign bus.e     = w_q[4];
  assign bus.f     = w_q[5];
  assign bus.v     = r_v;
  assign bus.err   = r_err;
  assign bus.wcnt  = r_wcnt;

endmodule

// File: tb/tb_demux6output16bit_reg.sv
// Directed bench: stimulus pushes hand-computed expectations tagged with the cycle they
// become due; a negedge monitor pops and compares them against the DUT outputs.
module tb_demux6output16bit_reg;
  import demux6_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  demux6output16bit_reg_if bus ();

  demux6output16bit_reg dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {K_REG, K_V, K_ERR, K_WCNT} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    int          idx;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Same select encoding as the downstream 6-input mux.
  function automatic logic [15:0] mux6(input int sel);
    case (sel)
      0:       return bus.a;
      1:       return bus.b;
      2:       return bus.c;
      3:       return bus.d_out;
      4:       return bus.e;
      5:       return bus.f;
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] observe(input kind_e k, input int idx);
    case (k)
      K_REG:   return mux6(idx);
      K_V:     return {10'd0, bus.v};
      K_ERR:   return {15'd0, bus.err};
      default: return {8'd0, bus.wcnt};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, observe(sb[i].kind, sb[i].idx), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input kind_e k, input int idx,
                           input logic [15:0] val, input string name);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = k;
    e.idx  = idx;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_state(input int dly, input logic [15:0] r [6], input logic [5:0] v,
                              input logic err, input logic [7:0] w, input string tag);
    for (int i = 0; i < 6; i++) begin
      expect_at(dly, K_REG, i, r[i], $sformatf("%s.reg%0d", tag, i));
    end
    expect_at(dly, K_V,    0, {10'd0, v},  {tag, ".v"});
    expect_at(dly, K_ERR,  0, {15'd0, err}, {tag, ".err"});
    expect_at(dly, K_WCNT, 0, {8'd0, w},   {tag, ".wcnt"});
  endtask

  task automatic expect_zero(input int dly, input string tag);
    expect_state(dly, '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 6'd0, 1'b0, 8'd0, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.we  = 1'b0;
    bus.clr = 1'b0;
    bus.s   = '0;
    bus.d   = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_zero(0, "reset");
    expect_zero(5, "idle");
    repeat (5) tick();

    // Sweep A..F; each value is invisible one edge after sampling and visible after two
    for (int i = 0; i < 6; i++) begin
      bus.we = 1'b1;
      bus.s  = 3'(i);
      bus.d  = 16'(i + 1);
      expect_at(1, K_REG, i, 16'd0, $sformatf("sweep_early%0d", i));
      expect_at(2, K_REG, i, 16'(i + 1), $sformatf("sweep%0d", i));
      tick();
    end
    bus.we = 1'b0;
    expect_state(1, '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6}, 6'h3F, 1'b0, 8'd6, "sweep_final");
    repeat (3) tick();

    // Illegal select
    bus.we = 1'b1;
    bus.s  = 3'd6;
    bus.d  = 16'hBEEF;
    expect_at(1, K_ERR, 0, 16'd0, "err_not_yet");
    expect_state(2, '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6}, 6'h3F, 1'b1, 8'd6, "illegal");
    tick();
    bus.we = 1'b0;
    expect_at(10, K_ERR, 0, 16'd1, "err_sticky");
    repeat (10) tick();

    // Back-to-back overwrite of C
    bus.we = 1'b1;
    bus.s  = 3'd2;
    bus.d  = 16'h1111;
    expect_at(2, K_REG,  2, 16'h1111, "ovr_first");
    expect_at(2, K_WCNT, 0, 16'd7,    "ovr_wcnt1");
    expect_at(3, K_REG,  2, 16'h2222, "ovr_second");
    expect_at(3, K_WCNT, 0, 16'd8,    "ovr_wcnt2");
    expect_at(3, K_REG,  1, 16'd2,    "ovr_hold_b");
    expect_at(3, K_REG,  3, 16'd4,    "ovr_hold_d");
    tick();
    bus.d = 16'h2222;
    tick();
    bus.we = 1'b0;
    repeat (3) tick();

    // CLR on the commit cycle, with a fresh request alongside it
    bus.we = 1'b1;
    bus.s  = 3'd4;
    bus.d  = 16'h00AA;
    tick();
    bus.clr = 1'b1;
    bus.s   = 3'd5;
    bus.d   = 16'h0055;
    expect_zero(1, "clr");
    tick();
    bus.clr = 1'b0;
    bus.we  = 1'b0;
    expect_zero(2, "clr_drop");
    repeat (3) tick();

    // 260 legal writes: counter saturates
    for (int i = 0; i < 260; i++) begin
      bus.we = 1'b1;
      bus.s  = 3'(i % 6);
      bus.d  = 16'(i);
      if (i == 253) expect_at(2, K_WCNT, 0, 16'd254, "sat_254");
      if (i == 254) expect_at(2, K_WCNT, 0, 16'd255, "sat_255");
      if (i == 257) begin
        expect_at(2, K_WCNT, 0, 16'd255,  "sat_hold");
        expect_at(2, K_REG,  5, 16'h0101, "sat_f");
      end
      tick();
    end

    // Async reset with write 259 (B <= 0x0103) still pending
    #2;
    rst_n  = 1'b0;
    bus.we = 1'b0;
    expect_zero(0, "async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    expect_zero(1, "post_rst");
    expect_zero(3, "post_rst_late");
    repeat (5) tick();

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
